uxrom_gen: RTL and testbench

Parametrised discrete-logic bank controller for the UxROM family: UxROM (fixed-last), fixed-first (mapper 180) and UNROM-512 (CHR-RAM banking plus one-screen mirroring). It runs on the system clock rather than on CPU M2: it detects M2 falling edges, resolves bus conflicts, and commits bank writes. It sits between the CPU/PPU bus decode and the PRG/CHR memory controllers, and replaces the fixed 5-bit UxROM register with width- and mode-configurable logic.

---
 rtl/uxrom_gen.sv | 149 ++++++++++++++
 tb/tb_uxrom_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uxrom_gen.sv
// UxROM-family bank controller (fixed-last, fixed-first, UNROM-512) clocked from the system clock.
// Define UXROM_GEN_SST_EN to enable the save-state read/write port.
module uxrom_gen #(
  parameter int PRG_BANK_W = 5,
  parameter int CHR_BANK_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_m2,
  input  logic [15:0]               cpu_addr,
  input  logic [7:0]                cpu_data,
  input  logic                      cpu_rw,
  input  logic [7:0]                prg_do,
  input  logic [1:0]                mode,
  input  logic                      bus_cf,
  input  logic                      mir_v,
  input  logic [13:0]               ppu_addr,
  output logic [14+PRG_BANK_W-1:0]  prg_addr,
  output logic                      prg_ce,
  output logic [13+CHR_BANK_W-1:0]  chr_addr,
  output logic                      ciram_a10,
  output logic                      wr_ack,
  input  logic                      sst_act,
  input  logic                      sst_we,
  input  logic [7:0]                sst_addr,
  input  logic [7:0]                sst_di,
  output logic [7:0]                sst_do
);

  localparam logic [1:0] CHR_MASK = 2'((1 << CHR_BANK_W) - 1);

  logic                  m2_p0, m2_p1, m2_p2, fall_p3;
  logic                  sh_a15, sh_rw;
  logic [7:0]            sh_data;
  logic [PRG_BANK_W-1:0] prg_bank, prg_win;
  logic [1:0]            chr_bank;
  logic                  onescr;
  logic [7:0]            eff_data;
  logic                  is_m1, is_m2;
  logic                  sst_block, sst_wr0, sst_wr1, cpu_commit;

  assign eff_data = bus_cf ? (cpu_data & prg_do) : cpu_data;
  assign is_m1    = (mode == 2'd1);
  assign is_m2    = (mode == 2'd2);

`ifdef UXROM_GEN_SST_EN
  assign sst_block = sst_act;
  assign sst_wr0   = sst_act & sst_we & (sst_addr == 8'd0);
  assign sst_wr1   = sst_act & sst_we & (sst_addr == 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sst_do <= 8'hFF;
    else if (sst_addr == 8'd0)
      sst_do <= 8'(prg_bank);
    else if (sst_addr == 8'd1)
      sst_do <= {onescr, chr_bank, 5'b0};
    else
      sst_do <= 8'hFF;
  end

  logic unused_bits;
  assign unused_bits = ^{ppu_addr[13], sh_data, sst_di};
`else
  assign sst_block = 1'b0;
  assign sst_wr0   = 1'b0;
  assign sst_wr1   = 1'b0;
  assign sst_do    = 8'hFF;

  logic unused_bits;
  assign unused_bits = ^{ppu_addr[13], sh_data, sst_act, sst_we, sst_addr, sst_di, chr_bank};
`endif

  // Stage p0..p2: M2 synchroniser and fall detector; p3 registers the detected fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_p0   <= 1'b0;
      m2_p1   <= 1'b0;
      m2_p2   <= 1'b0;
      fall_p3 <= 1'b0;
    end else begin
      m2_p0   <= cpu_m2;
      m2_p1   <= m2_p0;
      m2_p2   <= m2_p1;
      fall_p3 <= m2_p2 & ~m2_p1;
    end
  end

  // Shadow bus capture while synchronised M2 is high; holds through the fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a15  <= 1'b0;
      sh_rw   <= 1'b0;
      sh_data <= 8'h00;
    end else if (m2_p1) begin
      sh_a15  <= cpu_addr[15];
      sh_rw   <= cpu_rw;
      sh_data <= eff_data;
    end
  end

  assign cpu_commit = fall_p3 & sh_a15 & ~sh_rw & ~sst_block;

  // Stage p4: bank register commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prg_bank <= '0;
      chr_bank <= 2'b00;
      onescr   <= 1'b0;
      wr_ack   <= 1'b0;
    end else begin
      wr_ack <= cpu_commit;
      if (sst_wr0)
        prg_bank <= sst_di[PRG_BANK_W-1:0];
      if (sst_wr1) begin
        chr_bank <= sst_di[6:5] & CHR_MASK;
        onescr   <= sst_di[7];
      end
      if (cpu_commit) begin
        prg_bank <= sh_data[PRG_BANK_W-1:0];
        if (is_m2) begin
          chr_bank <= sh_data[6:5] & CHR_MASK;
          onescr   <= sh_data[7];
        end
      end
    end
  end

  always_comb begin
    prg_win = '1;
    if (cpu_addr[14])
      prg_win = is_m1 ? prg_bank : '1;
    else
      prg_win = is_m1 ? '0 : prg_bank;
  end

  assign prg_addr  = {prg_win, cpu_addr[13:0]};
  assign prg_ce    = cpu_addr[15];
  assign ciram_a10 = (is_m2 && onescr) ? 1'b1 : (mir_v ? ppu_addr[10] : ppu_addr[11]);

  generate
    if (CHR_BANK_W == 0) begin : g_chr_flat
      assign chr_addr = ppu_addr[12:0];
    end else begin : g_chr_bank
      assign chr_addr = {(is_m2 ? chr_bank[CHR_BANK_W-1:0] : CHR_BANK_W'(0)), ppu_addr[12:0]};
    end
  endgenerate

endmodule

// File: tb/tb_uxrom_gen.sv
// Directed bench for uxrom_gen with a behavioural bank/mapping model and per-cycle compare.
module tb_uxrom_gen;
  localparam int PW = 5;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_m2 = 1'b0;
  logic [15:0] cpu_addr = 16'h8000;
  logic [7:0]  cpu_data = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  prg_do = 8'h00;
  logic [1:0]  mode = 2'd0;
  logic        bus_cf = 1'b0;
  logic        mir_v = 1'b0;
  logic [13:0] ppu_addr = 14'h0000;
  logic [14+PW-1:0] prg_addr;
  logic        prg_ce;
  logic [13+CW-1:0] chr_addr;
  logic        ciram_a10;
  logic        wr_ack;
  logic        sst_act = 1'b0;
  logic        sst_we = 1'b0;
  logic [7:0]  sst_addr = 8'h00;
  logic [7:0]  sst_di = 8'h00;
  logic [7:0]  sst_do;

  uxrom_gen #(.PRG_BANK_W(PW), .CHR_BANK_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_m2(cpu_m2), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_rw(cpu_rw), .prg_do(prg_do), .mode(mode),
    .bus_cf(bus_cf), .mir_v(mir_v), .ppu_addr(ppu_addr), .prg_addr(prg_addr),
    .prg_ce(prg_ce), .chr_addr(chr_addr), .ciram_a10(ciram_a10), .wr_ack(wr_ack),
    .sst_act(sst_act), .sst_we(sst_we), .sst_addr(sst_addr), .sst_di(sst_di),
    .sst_do(sst_do)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int m_bank = 0;
  int m_chr = 0;
  int m_one = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int exp_prg(input int addr, input int md);
    int win;
    if ((addr % 32768) >= 16384) win = (md == 1) ? m_bank : (1 << PW) - 1;
    else                         win = (md == 1) ? 0 : m_bank;
    return win * 16384 + (addr % 16384);
  endfunction

  function automatic int exp_chr(input int paddr, input int md);
    return ((md == 2) ? m_chr * 8192 : 0) + (paddr % 8192);
  endfunction

  function automatic int exp_ciram(input int paddr, input int md, input int mv);
    if (md == 2 && m_one == 1) return 1;
    return mv ? ((paddr / 1024) % 2) : ((paddr / 2048) % 2);
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("prg_addr", 32'(prg_addr), 32'(exp_prg(int'(cpu_addr), int'(mode))));
      check("prg_ce", 32'(prg_ce), 32'(int'(cpu_addr) >= 32768));
      check("chr_addr", 32'(chr_addr), 32'(exp_chr(int'(ppu_addr), int'(mode))));
      check("ciram_a10", 32'(ciram_a10), 32'(exp_ciram(int'(ppu_addr), int'(mode), int'(mir_v))));
      check("wr_ack_idle", 32'(wr_ack), 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic [7:0] pd,
                           input logic rw, input bit exp_ack);
    int eff;
    chk_en = 1'b0;
    @(negedge clk);
    cpu_addr = a; cpu_data = d; prg_do = pd; cpu_rw = rw; cpu_m2 = 1'b1;
    repeat (3) @(negedge clk);
    cpu_m2 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("wr_ack_lat", 32'(wr_ack), 32'(exp_ack && i == 4));
    end
    cpu_rw = 1'b1; prg_do = 8'h00;
    if (exp_ack) begin
      eff = bus_cf ? int'(d & pd) : int'(d);
      m_bank = eff % (1 << PW);
      if (mode == 2'd2) begin
        m_chr = (eff / 32) % (1 << CW);
        m_one = eff / 128;
      end
    end
    chk_en = 1'b1;
  endtask

  task automatic lit_prg(input string name, input logic [15:0] a, input int req);
    cpu_addr = a;
    #1;
    check(name, 32'(prg_addr), 32'(req));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    step(2);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_sst_do", 32'(sst_do), 32'hFF);
    check("rst_prg8000", 32'(prg_addr), 32'h00000);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(2);

    lit_prg("m0_C000", 16'hC000, 32'h7C000);
    lit_prg("m0_8000", 16'h8000, 32'h00000);

    cpu_cycle(16'h8000, 8'h03, 8'hFF, 1'b0, 1'b1);
    lit_prg("w03_8123", 16'h8123, 32'h0C123);

    bus_cf = 1'b1;
    cpu_cycle(16'h8000, 8'h1F, 8'h05, 1'b0, 1'b1);
    bus_cf = 1'b0;
    lit_prg("bcf_8000", 16'h8000, 32'h14000);

    cpu_cycle(16'h8000, 8'h09, 8'hFF, 1'b1, 1'b0);
    cpu_cycle(16'h4000, 8'h09, 8'hFF, 1'b0, 1'b0);
    lit_prg("noack_8000", 16'h8000, 32'h14000);

    mode = 2'd1;
    cpu_cycle(16'h8000, 8'h02, 8'hFF, 1'b0, 1'b1);
    lit_prg("m1_8000", 16'h8000, 32'h00000);
    lit_prg("m1_C010", 16'hC010, 32'h08010);

    mode = 2'd2;
    cpu_cycle(16'hC000, 8'hC1, 8'hFF, 1'b0, 1'b1);
    lit_prg("m2_8000", 16'h8000, 32'h04000);
    ppu_addr = 14'h0010;
    #1;
    check("m2_chr", 32'(chr_addr), 32'h4010);
    check("m2_onescr", 32'(ciram_a10), 32'd0 + 1);
    step(1);

    mode = 2'd0;
    step(1);
    ppu_addr = 14'h0400; mir_v = 1'b1; step(1);
    ppu_addr = 14'h0800; step(1);
    mir_v = 1'b0; step(1);
    mode = 2'd3;
    lit_prg("m3_C000", 16'hC000, 32'h7C000);
    mode = 2'd2; ppu_addr = 14'h0010;
    step(2);
    cpu_cycle(16'h8000, 8'h21, 8'hFF, 1'b0, 1'b1);
    ppu_addr = 14'h0800; step(2);

    chk_en = 1'b0;
    @(negedge clk);
    cpu_addr = 16'h8000; cpu_data = 8'h06; cpu_rw = 1'b0; cpu_m2 = 1'b1;
    step(3);
    cpu_m2 = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    check("drop_ack", 32'(wr_ack), 32'd0);
    rst_n = 1'b1; cpu_rw = 1'b1;
    m_bank = 0; m_chr = 0; m_one = 0;
    step(2);
    check("drop_ack2", 32'(wr_ack), 32'd0);
    check("drop_prg", 32'(prg_addr), 32'h00000);
    chk_en = 1'b1;
    step(2);

`ifdef UXROM_GEN_SST_EN
    sst_act = 1'b1; sst_we = 1'b1; sst_addr = 8'h00; sst_di = 8'h07;
    cpu_cycle(16'h8000, 8'h02, 8'hFF, 1'b0, 1'b0);
    chk_en = 1'b0;
    m_bank = 7;
    sst_we = 1'b0;
    step(2);
    check("sst_do0", 32'(sst_do), 32'h07);
    sst_addr = 8'h01; sst_di = 8'hC0; sst_we = 1'b1;
    step(1);
    sst_we = 1'b0;
    m_chr = 2; m_one = 1;
    step(2);
    check("sst_do1", 32'(sst_do), 32'hC0);
    sst_act = 1'b0;
    chk_en = 1'b1;
    step(2);
    rst_n = 1'b0;
    step(1);
    check("sst_rst", 32'(sst_do), 32'hFF);
    rst_n = 1'b1;
    m_bank = 0; m_chr = 0; m_one = 0;
    step(2);
    check("sst_do1_zero", 32'(sst_do), 32'h00);
    check("sst_prg_zero", 32'(prg_addr), 32'h00000);
`else
    sst_act = 1'b1; sst_we = 1'b1; sst_addr = 8'h00; sst_di = 8'h07;
    cpu_cycle(16'h8000, 8'h02, 8'hFF, 1'b0, 1'b1);
    check("nosst_do", 32'(sst_do), 32'hFF);
    lit_prg("nosst_8000", 16'h8000, 32'h08000);
    sst_act = 1'b0; sst_we = 1'b0;
`endif
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
